insn_mem_loader: RTL and testbench

- Instruction-side responder for the pipeline CPU fetch interface: answers `rd_insn_en`/`pc` with `insn` from an on-chip word array.
- Also owns the CPU run gate: it fills the array from a byte stream (UART/host loader), then asserts `cpu_en`.
- Sits between the loader link and `pipeline_cpu_top`, replacing the bench-side disk model.

---
 rtl/insn_mem_loader_pkg.sv | 22 ++
 rtl/insn_mem_array.sv | 25 ++
 rtl/insn_mem_loader.sv | 156 +++++++++++++++
 tb/tb_insn_mem_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/insn_mem_loader_pkg.sv
// rtl/insn_mem_loader_pkg.sv - shared constants and loader state encoding
`timescale 1ps/1ps
package insn_mem_loader_pkg;

   localparam int DEPTH          = 32;
   localparam int ADDR_W         = 5;
   localparam int PC_WIDTH       = 32;
   localparam int WORD_WIDTH     = 32;
   localparam int LOAD_LEN_BYTES = 2;
   localparam int CNT_W          = 16;

   localparam logic [WORD_WIDTH-1:0] NOP_INSN = 32'h0000_0013;

   // Loader FSM states; RUN is the only state in which the CPU is enabled
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LEN  = 2'd1,
      ST_DATA = 2'd2,
      ST_RUN  = 2'd3
   } load_state_t;

endpackage

// File: rtl/insn_mem_array.sv
// rtl/insn_mem_array.sv - instruction word storage, sync write, comb read
`timescale 1ps/1ps
module insn_mem_array
   import insn_mem_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [WORD_WIDTH-1:0] i_wdata,
   input  logic [ADDR_W-1:0]     i_raddr,
   output logic [WORD_WIDTH-1:0] o_rdata
);

   logic [WORD_WIDTH-1:0] r_mem [DEPTH];

   // Contents are deliberately not reset; a program load defines them
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/insn_mem_loader.sv
// rtl/insn_mem_loader.sv - byte-stream program loader, CPU run gate and fetch responder
`timescale 1ps/1ps
module insn_mem_loader
   import insn_mem_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  cpu_en,
   input  logic                  rd_insn_en,
   input  logic [PC_WIDTH-1:0]   pc,
   output logic [WORD_WIDTH-1:0] insn,
   output logic                  insn_misalign,
   output logic                  load_overflow
);

   localparam logic [PC_WIDTH-1:0] PC_LIMIT  = PC_WIDTH'(DEPTH * 4);
   localparam logic [CNT_W-1:0]    WIDX_LIM  = CNT_W'(DEPTH);
   localparam logic [1:0]          LEN_LAST  = 2'(LOAD_LEN_BYTES - 1);

   load_state_t           r_state;
   load_state_t           w_next_state;
   logic                  r_cpu_en;
   logic                  r_overflow;
   logic [1:0]            r_byte_cnt;
   logic [CNT_W-1:0]      r_len;
   logic [CNT_W-1:0]      r_widx;
   logic [23:0]           r_word;

   logic                  w_rx_ready;
   logic                  w_fire;
   logic                  w_word_done;
   logic                  w_last_word;
   logic [CNT_W-1:0]      w_len_full;
   logic                  w_we;
   logic [WORD_WIDTH-1:0] w_rdata;

   // A coincident load_start always wins, so the byte on that cycle is refused
   assign w_rx_ready  = ((r_state == ST_LEN) || (r_state == ST_DATA)) && !load_start;
   assign w_fire      = rx_valid && w_rx_ready;
   assign w_word_done = w_fire && (r_state == ST_DATA) && (r_byte_cnt == 2'd3);
   assign w_last_word = (r_widx == (r_len - CNT_W'(1)));
   assign w_len_full  = {rx_data, r_len[7:0]};
   // Words past the array end are still consumed so the stream stays framed
   assign w_we        = w_word_done && (r_widx < WIDX_LIM);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; load_start restarts the load from any state
   always_comb begin
      w_next_state = r_state;
      if (load_start) begin
         w_next_state = ST_LEN;
      end else begin
         case (r_state)
            ST_IDLE: w_next_state = ST_IDLE;
            ST_LEN: begin
               if (w_fire && (r_byte_cnt == LEN_LAST)) begin
                  w_next_state = (w_len_full == '0) ? ST_RUN : ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_word_done && w_last_word) begin
                  w_next_state = ST_RUN;
               end
            end
            ST_RUN:  w_next_state = ST_RUN;
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   // Byte assembly, word counting, overflow flag and registered run gate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cpu_en   <= 1'b0;
         r_overflow <= 1'b0;
         r_byte_cnt <= 2'd0;
         r_len      <= '0;
         r_widx     <= '0;
         r_word     <= '0;
      end else begin
         r_cpu_en <= (w_next_state == ST_RUN);
         if (load_start) begin
            r_overflow <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_len      <= '0;
            r_widx     <= '0;
            r_word     <= '0;
         end else if (w_fire) begin
            if (r_state == ST_LEN) begin
               if (r_byte_cnt == LEN_LAST) begin
                  r_len[15:8] <= rx_data;
                  r_byte_cnt  <= 2'd0;
               end else begin
                  r_len[7:0]  <= rx_data;
                  r_byte_cnt  <= r_byte_cnt + 2'd1;
               end
            end else begin
               r_byte_cnt <= r_byte_cnt + 2'd1;
               case (r_byte_cnt)
                  2'd0: r_word[7:0]   <= rx_data;
                  2'd1: r_word[15:8]  <= rx_data;
                  2'd2: r_word[23:16] <= rx_data;
                  default: begin
                     r_widx <= r_widx + CNT_W'(1);
                     if (r_widx >= WIDX_LIM) begin
                        r_overflow <= 1'b1;
                     end
                  end
               endcase
            end
         end
      end
   end

   insn_mem_array u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_widx[ADDR_W-1:0]),
      .i_wdata ({rx_data, r_word}),
      .i_raddr (pc[ADDR_W+1:2]),
      .o_rdata (w_rdata)
   );

   // Fetch mux: zero-latency read, NOP for misaligned or out-of-range pc
   always_comb begin
      insn          = '0;
      insn_misalign = 1'b0;
      if (rd_insn_en && r_cpu_en) begin
         if (pc[1:0] != 2'b00) begin
            insn          = NOP_INSN;
            insn_misalign = 1'b1;
         end else if (pc >= PC_LIMIT) begin
            insn = NOP_INSN;
         end else begin
            insn = w_rdata;
         end
      end
   end

   assign rx_ready      = w_rx_ready;
   assign cpu_en        = r_cpu_en;
   assign load_overflow = r_overflow;

endmodule

// File: tb/tb_insn_mem_loader.sv
// tb/tb_insn_mem_loader.sv - scoreboard bench for insn_mem_loader
`timescale 1ps/1ps
module tb_insn_mem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        cpu_en;
   logic        rd_insn_en = 1'b0;
   logic [31:0] pc = 32'h0;
   logic [31:0] insn;
   logic        insn_misalign;
   logic        load_overflow;

   int          n_vec = 0;
   int          n_mis = 0;
   logic [31:0] sb_q[$];
   logic [31:0] ovf_words[33];

   localparam logic [31:0] NOP = 32'h0000_0013;

   always #5 clk = ~clk;

   insn_mem_loader dut (
      .clk           (clk),
      .rst           (rst),
      .load_start    (load_start),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .cpu_en        (cpu_en),
      .rd_insn_en    (rd_insn_en),
      .pc            (pc),
      .insn          (insn),
      .insn_misalign (insn_misalign),
      .load_overflow (load_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_load_start();
      @(negedge clk);
      load_start = 1'b1;
      @(posedge clk);
      #1 load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t;
      if (gap) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready) check("rx_ready_timeout", {31'b0, rx_ready}, 32'h1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], gap);
   endtask

   task automatic fetch(input string tag, input logic [31:0] a, input logic en, input logic [31:0] exp);
      @(negedge clk);
      rd_insn_en = en;
      pc         = a;
      sb_q.push_back(exp);
      #1;
      check(tag, insn, sb_q.pop_front());
   endtask

   task automatic basic_load(input string tag);
      logic [31:0] w1;
      w1 = 32'h0020_0593;
      pulse_load_start();
      check({tag, "_cpu_en_off"}, {31'b0, cpu_en}, 32'h0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_word(32'h0010_0513, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(w1[i*8 +: 8], 1'b0);
      check({tag, "_cpu_en_pre"}, {31'b0, cpu_en}, 32'h0);
      send_byte(w1[31:24], 1'b0);
      check({tag, "_cpu_en_post"}, {31'b0, cpu_en}, 32'h1);
      fetch({tag, "_pc0"}, 32'h0, 1'b1, 32'h0010_0513);
      fetch({tag, "_pc4"}, 32'h4, 1'b1, 32'h0020_0593);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #22 rst = 1'b0;

      // Reset then idle
      #1;
      check("rst_cpu_en", {31'b0, cpu_en}, 32'h0);
      check("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
      check("rst_overflow", {31'b0, load_overflow}, 32'h0);
      fetch("rst_insn", 32'h0, 1'b1, 32'h0);

      // Basic load
      basic_load("basic");

      // Overflow: 33 words, only the first 32 stored
      for (int i = 0; i < 33; i++) ovf_words[i] = 32'hA500_0000 | (i * 32'h0001_0101);
      pulse_load_start();
      check("ovf_cpu_en_off", {31'b0, cpu_en}, 32'h0);
      send_byte(8'h21, 1'b0);
      send_byte(8'h00, 1'b0);
      for (int i = 0; i < 32; i++) send_word(ovf_words[i], 1'b0);
      check("ovf_flag_pre", {31'b0, load_overflow}, 32'h0);
      check("ovf_cpu_en_pre", {31'b0, cpu_en}, 32'h0);
      send_word(ovf_words[32], 1'b0);
      check("ovf_flag", {31'b0, load_overflow}, 32'h1);
      check("ovf_cpu_en", {31'b0, cpu_en}, 32'h1);
      for (int i = 0; i < 32; i++) fetch($sformatf("ovf_mem%0d", i), i * 4, 1'b1, ovf_words[i]);

      // Boundary fetches
      fetch("bnd_pc7c", 32'h7C, 1'b1, ovf_words[31]);
      fetch("bnd_pc80", 32'h80, 1'b1, NOP);
      check("bnd_pc80_mis", {31'b0, insn_misalign}, 32'h0);
      fetch("bnd_pc2", 32'h2, 1'b1, NOP);
      check("bnd_pc2_mis", {31'b0, insn_misalign}, 32'h1);
      fetch("bnd_en0", 32'h2, 1'b0, 32'h0);
      check("bnd_en0_mis", {31'b0, insn_misalign}, 32'h0);

      // Back-pressure and restart mid-word
      pulse_load_start();
      check("bp_cpu_en_off", {31'b0, cpu_en}, 32'h0);
      check("bp_ovf_clr", {31'b0, load_overflow}, 32'h0);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hEF, 1'b1);
      send_byte(8'hBE, 1'b1);
      @(negedge clk);
      rx_data    = 8'hAD;
      rx_valid   = 1'b1;
      load_start = 1'b1;
      #1;
      check("bp_restart_ready", {31'b0, rx_ready}, 32'h0);
      @(posedge clk);
      #1;
      load_start = 1'b0;
      rx_valid   = 1'b0;
      check("bp_restart_cpu_en", {31'b0, cpu_en}, 32'h0);
      send_byte(8'h00, 1'b1);
      check("bp_len0_mid", {31'b0, cpu_en}, 32'h0);
      send_byte(8'h00, 1'b1);
      check("bp_len0_run", {31'b0, cpu_en}, 32'h1);
      fetch("bp_mem0_kept", 32'h0, 1'b1, ovf_words[0]);

      // Reset mid-DATA
      pulse_load_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_cpu_en", {31'b0, cpu_en}, 32'h0);
      check("mid_rst_ready", {31'b0, rx_ready}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_cpu_en", {31'b0, cpu_en}, 32'h0);
      check("post_rst_ready", {31'b0, rx_ready}, 32'h0);
      fetch("post_rst_insn", 32'h0, 1'b1, 32'h0);
      basic_load("reload");

      if (sb_q.size() != 0) check("sb_drain", sb_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
